serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single `full_adder` cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in. It accepts an operation through a valid/ready request port and returns sum, carry-out and signed-overflow through a valid/ready result port. It is the sequencing layer that lets one 1-bit adder cell serve multi-bit arithmetic where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/full_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and an elaboration-time clog2 used to size the bit counter.
// Latency: n/a (constants and a constant function only). Backpressure: n/a.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(9) = 4.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the only arithmetic element of the serial adder.
// Latency: combinational. Backpressure: n/a.
// Ports: a, b, c_in -> s (sum), c_out (carry).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: sequences one full_adder over WIDTH cycles, LSB first.
// Latency: accept at edge k, done_valid high after edge k+WIDTH; issue interval WIDTH+2.
// Backpressure: result and done_valid hold until done_ready; start_ready only in IDLE.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start_valid/start_ready      request handshake; a_in, b_in, c_in sampled on accept
//   done_valid/done_ready        result handshake
//   sum_out, c_out, ovf          registered sum, carry out, signed overflow
//   busy                         high while in RUN or DONE
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   localparam int                CNT_W    = clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] sum_out_q, sum_out_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_cout;
   logic             accept;
   logic             running;
   logic             last_bit;
   logic             msb_cin;
   // Complete sum as it would stand after the bit processed this cycle.
   logic [WIDTH-1:0] sum_full;

   assign accept   = (state_q == ST_IDLE) && start_valid;
   assign running  = (state_q == ST_RUN);
   assign last_bit = (bit_cnt_q == LAST_BIT);
   // On the MSB cycle the carry register holds the carry into the MSB.
   assign msb_cin  = carry_q;

   full_adder u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c_in  (carry_q),
      .s     (fa_s),
      .c_out (fa_cout)
   );

   // Sum shifter. Only WIDTH-1 earlier bits need storing: the MSB comes
   // straight from the cell on the final cycle, so the shifter is one bit
   // narrower than the operand and vanishes entirely for WIDTH=1.
   if (WIDTH > 1) begin : g_sum_sh
      logic [WIDTH-2:0] sum_sh_q, sum_sh_d;

      assign sum_full = {fa_s, sum_sh_q};

      always_comb begin
         sum_sh_d = sum_sh_q;
         if (accept) begin
            sum_sh_d = '0;
         end else if (running) begin
            sum_sh_d = sum_full[WIDTH-1:1];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sum_sh_q <= '0;
         end else begin
            sum_sh_q <= sum_sh_d;
         end
      end
   end else begin : g_no_sum_sh
      assign sum_full = fa_s;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_valid) state_d = ST_RUN;
         ST_RUN:  if (last_bit)    state_d = ST_DONE;
         ST_DONE: if (done_ready)  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (registered state only) ----------------
   always_comb begin
      start_ready = 1'b0;
      done_valid  = 1'b0;
      busy        = 1'b0;
      case (state_q)
         ST_IDLE: start_ready = 1'b1;
         ST_RUN:  busy        = 1'b1;
         ST_DONE: begin
            busy       = 1'b1;
            done_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      carry_d   = carry_q;
      bit_cnt_d = bit_cnt_q;
      sum_out_d = sum_out_q;
      c_out_d   = c_out_q;
      ovf_d     = ovf_q;

      if (accept) begin
         a_sh_d    = a_in;
         b_sh_d    = b_in;
         carry_d   = c_in;
         bit_cnt_d = '0;
      end else if (running) begin
         a_sh_d    = a_sh_q >> 1;
         b_sh_d    = b_sh_q >> 1;
         carry_d   = fa_cout;
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
         // Result registers change only on the RUN->DONE step.
         if (last_bit) begin
            sum_out_d = sum_full;
            c_out_d   = fa_cout;
            ovf_d     = msb_cin ^ fa_cout;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         carry_q   <= 1'b0;
         bit_cnt_q <= '0;
         sum_out_q <= '0;
         c_out_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         carry_q   <= carry_d;
         bit_cnt_q <= bit_cnt_d;
         sum_out_q <= sum_out_d;
         c_out_q   <= c_out_d;
         ovf_q     <= ovf_d;
      end
   end

   assign sum_out = sum_out_q;
   assign c_out   = c_out_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 with a result scoreboard.
// Latency: n/a. Backpressure: done_ready is driven low for a stretch to hold results.
module tb_serial_adder_ctrl;

   localparam int CLK_P = 10;

   logic clk = 1'b0;
   always #(CLK_P/2) clk = ~clk;

   logic rst;

   logic       sv8, sr8, dv8, dr8, ci8, co8, ovf8, busy8;
   logic [7:0] a8, b8, sum8;

   logic       sv1, sr1, dv1, dr1, ci1, co1, ovf1, busy1;
   logic [0:0] a1, b1, sum1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {logic [7:0] sum; logic c; logic o;} res8_t;
   typedef struct packed {logic [0:0] sum; logic c; logic o;} res1_t;
   res8_t q8[$];
   res1_t q1[$];

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .start_valid(sv8), .start_ready(sr8),
      .a_in(a8), .b_in(b8), .c_in(ci8),
      .done_valid(dv8), .done_ready(dr8),
      .sum_out(sum8), .c_out(co8), .ovf(ovf8), .busy(busy8)
   );

   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .start_valid(sv1), .start_ready(sr1),
      .a_in(a1), .b_in(b1), .c_in(ci1),
      .done_valid(dv1), .done_ready(dr1),
      .sum_out(sum1), .c_out(co1), .ovf(ovf1), .busy(busy1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: a result is compared on the cycle it is handed over.
   always @(negedge clk) begin
      if (dv8 === 1'b1 && dr8 === 1'b1) begin
         res8_t e;
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w8_unexpected_result: got sum %0h with no expected entry", sum8);
         end else begin
            e = q8.pop_front();
            check("w8_sum", 32'(sum8), 32'(e.sum));
            check("w8_cout", 32'(co8), 32'(e.c));
            check("w8_ovf", 32'(ovf8), 32'(e.o));
         end
      end
   end

   always @(negedge clk) begin
      if (dv1 === 1'b1 && dr1 === 1'b1) begin
         res1_t e;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w1_unexpected_result: got sum %0h with no expected entry", sum1);
         end else begin
            e = q1.pop_front();
            check("w1_sum", 32'(sum1), 32'(e.sum));
            check("w1_cout", 32'(co1), 32'(e.c));
            check("w1_ovf", 32'(ovf1), 32'(e.o));
         end
      end
   end

   // Issue one WIDTH=8 operation; returns just after the accept edge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input bit push, output time acc_t);
      int n;
      res8_t r;
      @(posedge clk); #1;
      n = 0;
      while (!sr8 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!sr8) check("w8_ready_timeout", 32'(sr8), 32'd1);
      if (push) begin
         r.sum = es; r.c = ec; r.o = eo;
         q8.push_back(r);
      end
      a8 = a; b8 = b; ci8 = ci; sv8 = 1'b1;
      @(posedge clk);
      acc_t = $time;
      #1;
      sv8 = 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
   endtask

   task automatic op1(input logic a, input logic b, input logic ci,
                      input logic es, input logic ec, input logic eo);
      int n;
      res1_t r;
      @(posedge clk); #1;
      n = 0;
      while (!sr1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!sr1) check("w1_ready_timeout", 32'(sr1), 32'd1);
      r.sum = es; r.c = ec; r.o = eo;
      q1.push_back(r);
      a1 = a; b1 = b; ci1 = ci; sv1 = 1'b1;
      @(posedge clk); #1;
      sv1 = 1'b0;
   endtask

   // Edges counted from just after the accept edge until done_valid is seen.
   task automatic wait_done8(output int n);
      n = 0;
      while (!dv8 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_done1(output int n);
      n = 0;
      while (!dv1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      #(CLK_P * 20000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  n;
      int  seen;
      time t0, t1, t2;
      logic [2:0] tbl [8];
      logic [2:0] v;
      logic [2:0] e;

      // Full-adder truth table, index {a,b,c_in}, entry {s,c_out,ovf=c_in^c_out}.
      tbl[0] = 3'b000; tbl[1] = 3'b101; tbl[2] = 3'b100; tbl[3] = 3'b010;
      tbl[4] = 3'b100; tbl[5] = 3'b010; tbl[6] = 3'b011; tbl[7] = 3'b110;

      // Reset with random inputs on both instances.
      rst = 1'b1;
      sv8 = 1'($urandom); dr8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      sv1 = 1'($urandom); dr1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      @(posedge clk); #1;
      check("rst_w8_start_ready", 32'(sr8), 32'd1);
      check("rst_w8_busy", 32'(busy8), 32'd0);
      check("rst_w8_done_valid", 32'(dv8), 32'd0);
      check("rst_w8_sum", 32'(sum8), 32'd0);
      check("rst_w8_cout", 32'(co8), 32'd0);
      check("rst_w8_ovf", 32'(ovf8), 32'd0);
      check("rst_w1_start_ready", 32'(sr1), 32'd1);
      check("rst_w1_busy", 32'(busy1), 32'd0);
      check("rst_w1_done_valid", 32'(dv1), 32'd0);
      check("rst_w1_sum", 32'(sum1), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      sv8 = 1'b0; dr8 = 1'b1;
      sv1 = 1'b0; dr1 = 1'b1;

      // Basic additions with latency checks.
      op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1, t0);
      wait_done8(n);
      check("w8_latency_5a33", 32'(n), 32'd8);
      check("w8_busy_in_done", 32'(busy8), 32'd1);
      check("w8_not_ready_in_done", 32'(sr8), 32'd0);

      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, t0);
      wait_done8(n);
      check("w8_latency_ff01", 32'(n), 32'd8);

      op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, t0);
      wait_done8(n);
      check("w8_latency_ffff", 32'(n), 32'd8);

      // Backpressure, with start pulses during RUN and DONE that must be ignored.
      @(posedge clk); #1;
      dr8 = 1'b0;
      op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      a8 = 8'hAA; b8 = 8'hAA; sv8 = 1'b1;
      @(posedge clk); #1;
      sv8 = 1'b0;
      wait_done8(n);
      check("w8_done_after_bp_op", 32'(dv8), 32'd1);
      for (int i = 0; i < 5; i++) begin
         sv8 = 1'b1;
         @(posedge clk); #1;
         check("w8_bp_done_valid", 32'(dv8), 32'd1);
         check("w8_bp_sum_hold", 32'(sum8), 32'h46);
         check("w8_bp_cout_hold", 32'(co8), 32'd0);
         check("w8_bp_ovf_hold", 32'(ovf8), 32'd0);
      end
      sv8 = 1'b0;
      dr8 = 1'b1;
      @(posedge clk); #1;
      check("w8_ready_after_xfer", 32'(sr8), 32'd1);
      check("w8_valid_drop_after_xfer", 32'(dv8), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (dv8 || busy8) seen++;
      end
      check("w8_no_second_op", 32'(seen), 32'd0);

      // Back-to-back operations with done_ready held high.
      op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, t0);
      op8(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, t1);
      op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, t2);
      check("w8_issue_gap_1", 32'(t1 - t0), 32'(CLK_P * 10));
      check("w8_issue_gap_2", 32'(t2 - t1), 32'(CLK_P * 10));
      wait_done8(n);
      check("w8_latency_8080", 32'(n), 32'd8);
      @(posedge clk); #1;

      // Reset on the third RUN cycle aborts the operation.
      op8(8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, t0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("w8_midrst_start_ready", 32'(sr8), 32'd1);
      check("w8_midrst_busy", 32'(busy8), 32'd0);
      check("w8_midrst_done_valid", 32'(dv8), 32'd0);
      check("w8_midrst_sum", 32'(sum8), 32'd0);
      check("w8_midrst_cout", 32'(co8), 32'd0);
      check("w8_midrst_ovf", 32'(ovf8), 32'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (dv8) seen++;
      end
      check("w8_midrst_no_done", 32'(seen), 32'd0);
      op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, t0);
      wait_done8(n);
      check("w8_latency_1020", 32'(n), 32'd8);
      @(posedge clk); #1;

      // WIDTH=1: every full-adder input combination.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         e = tbl[i];
         op1(v[2], v[1], v[0], e[2], e[1], e[0]);
         wait_done1(n);
         check("w1_latency", 32'(n), 32'd1);
      end

      repeat (4) @(posedge clk);
      #1;
      check("w8_scoreboard_empty", 32'(q8.size()), 32'd0);
      check("w1_scoreboard_empty", 32'(q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
